// File: rtl/axis_output_pipe.sv
// Width-down serializer from the conv-engine result stream to the S2MM DMA stream.
// Optional OUTPUT_PIPE_TKEEP_EN adds s_axis_tkeep and trims trailing empty sub-beats on tlast.
module axis_output_pipe #(
    parameter int WORD_WIDTH  = 8,
    parameter int S_WORDS     = 32,
    parameter int M_WORDS     = 8,
    parameter int TUSER_WIDTH = 8,
    parameter int I_IS_CONFIG = 3
) (
    input  logic                              aclk,
    input  logic                              areset,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    input  logic [S_WORDS*WORD_WIDTH-1:0]     s_axis_tdata,
    input  logic [TUSER_WIDTH-1:0]            s_axis_tuser,
`ifdef OUTPUT_PIPE_TKEEP_EN
    input  logic [S_WORDS*WORD_WIDTH/8-1:0]   s_axis_tkeep,
`endif
    input  logic                              m_axis_tready,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    output logic [M_WORDS*WORD_WIDTH-1:0]     m_axis_tdata,
    output logic [M_WORDS*WORD_WIDTH/8-1:0]   m_axis_tkeep
);

    localparam int RATIO  = S_WORDS / M_WORDS;
    localparam int CNT_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int S_BITS = S_WORDS * WORD_WIDTH;
    localparam int M_BITS = M_WORDS * WORD_WIDTH;
    localparam int M_KEEP = M_BITS / 8;

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    localparam logic [CNT_W-1:0] LAST_FULL = CNT_W'(RATIO - 1);

    logic [0:0]        state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  last_idx_r;
    logic [S_BITS-1:0] hold_data_r;
    logic              hold_last_r;

    logic              is_config_s;
    logic              final_beat_s;
    logic              in_hs_s;
    logic              out_hs_s;
    logic [CNT_W-1:0]  load_last_idx_s;
    logic [M_BITS-1:0] data_slices_s [RATIO];
    logic              unused_tuser_s;

    assign unused_tuser_s = ^s_axis_tuser;
    assign is_config_s    = s_axis_tuser[I_IS_CONFIG];
    assign final_beat_s   = (cnt_r == last_idx_r);
    assign s_axis_tready  = !areset && ((state_r == EMPTY) || (m_axis_tready && final_beat_s));
    assign in_hs_s        = s_axis_tvalid && s_axis_tready;
    assign out_hs_s       = (state_r == DRAIN) && m_axis_tready;

    for (genvar g = 0; g < RATIO; g++) begin : g_slice
        assign data_slices_s[g] = hold_data_r[g*M_BITS +: M_BITS];
    end

`ifdef OUTPUT_PIPE_TKEEP_EN
    localparam int S_KEEP = S_BITS / 8;

    logic [S_KEEP-1:0] hold_keep_r;
    logic [M_KEEP-1:0] keep_slices_s [RATIO];

    for (genvar g = 0; g < RATIO; g++) begin : g_keep_slice
        assign keep_slices_s[g] = hold_keep_r[g*M_KEEP +: M_KEEP];
    end

    // Highest sub-beat carrying any enabled byte; all-empty beats still emit slice 0.
    function automatic logic [CNT_W-1:0] calc_last_idx(input logic [S_KEEP-1:0] keep);
        logic [CNT_W-1:0] idx;
        idx = {CNT_W{1'b0}};
        for (int k = 0; k < RATIO; k++) begin
            if (|keep[k*M_KEEP +: M_KEEP]) begin
                idx = CNT_W'(k);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Trim only the final beat of a packet; mid-packet beats always send every slice.
    always_comb begin
        load_last_idx_s = LAST_FULL;
        if (s_axis_tlast) begin
            load_last_idx_s = calc_last_idx(s_axis_tkeep);
        end else begin
            load_last_idx_s = LAST_FULL;
        end
    end

    // Byte-enable holding register, loaded alongside the data.
    always_ff @(posedge aclk) begin
        if (areset) begin
            hold_keep_r <= {S_KEEP{1'b0}};
        end else if (in_hs_s && !is_config_s) begin
            hold_keep_r <= s_axis_tkeep;
        end else begin
            hold_keep_r <= hold_keep_r;
        end
    end

    // Output byte enables follow the current slice of the held keep.
    always_comb begin
        m_axis_tkeep = keep_slices_s[cnt_r];
    end
`else
    // Without input keep every emitted sub-beat is full.
    always_comb begin
        load_last_idx_s = LAST_FULL;
        if (state_r == DRAIN) begin
            m_axis_tkeep = {M_KEEP{1'b1}};
        end else begin
            m_axis_tkeep = {M_KEEP{1'b0}};
        end
    end
`endif

    // Control and data holding state; a new load wins over the end of the current drain.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r     <= EMPTY;
            cnt_r       <= {CNT_W{1'b0}};
            last_idx_r  <= {CNT_W{1'b0}};
            hold_data_r <= {S_BITS{1'b0}};
            hold_last_r <= 1'b0;
        end else if (in_hs_s && !is_config_s) begin
            state_r     <= DRAIN;
            cnt_r       <= {CNT_W{1'b0}};
            last_idx_r  <= load_last_idx_s;
            hold_data_r <= s_axis_tdata;
            hold_last_r <= s_axis_tlast;
        end else if (in_hs_s) begin
            state_r     <= EMPTY;
            cnt_r       <= {CNT_W{1'b0}};
        end else if (out_hs_s) begin
            if (final_beat_s) begin
                state_r <= EMPTY;
                cnt_r   <= {CNT_W{1'b0}};
            end else begin
                cnt_r   <= cnt_r + CNT_W'(1'b1);
            end
        end else begin
            state_r <= state_r;
            cnt_r   <= cnt_r;
        end
    end

    // Output beat is a pure function of registered state.
    always_comb begin
        m_axis_tvalid = (state_r == DRAIN);
        m_axis_tdata  = data_slices_s[cnt_r];
        if (state_r == DRAIN) begin
            m_axis_tlast = hold_last_r && final_beat_s;
        end else begin
            m_axis_tlast = 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_output_pipe.sv
// Directed bench for axis_output_pipe: serialization, back-to-back, backpressure,
// config drop, reset mid-drain and (with OUTPUT_PIPE_TKEEP_EN) keep trimming.
module tb_axis_output_pipe;

    logic         aclk = 1'b0;
    logic         areset;
    logic         s_axis_tready;
    logic         s_axis_tvalid;
    logic         s_axis_tlast;
    logic [255:0] s_axis_tdata;
    logic [7:0]   s_axis_tuser;
`ifdef OUTPUT_PIPE_TKEEP_EN
    logic [31:0]  s_axis_tkeep;
`endif
    logic         m_axis_tready;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic [63:0]  m_axis_tdata;
    logic [7:0]   m_axis_tkeep;

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0] in_base [8];
    logic       in_last [8];
    logic       in_cfg  [8];

    always #5 aclk = ~aclk;

    axis_output_pipe dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tready (s_axis_tready),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tuser  (s_axis_tuser),
`ifdef OUTPUT_PIPE_TKEEP_EN
        .s_axis_tkeep  (s_axis_tkeep),
`endif
        .m_axis_tready (m_axis_tready),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep)
    );

    task automatic check_value(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] beat_data(input logic [7:0] base);
        logic [255:0] d;
        for (int i = 0; i < 32; i++) begin
            d[i*8 +: 8] = base + 8'(i);
        end
        return d;
    endfunction

    function automatic logic [63:0] slice_of(input logic [7:0] base, input int k);
        logic [255:0] d;
        d = beat_data(base);
        return d[k*64 +: 64];
    endfunction

    task automatic drive_beat(input int i);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = beat_data(in_base[i]);
        s_axis_tlast  = in_last[i];
        s_axis_tuser  = in_cfg[i] ? 8'h08 : 8'hF7;
`ifdef OUTPUT_PIPE_TKEEP_EN
        s_axis_tkeep  = 32'hFFFF_FFFF;
`endif
    endtask

    task automatic drive_idle();
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 256'd0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 8'h00;
`ifdef OUTPUT_PIPE_TKEEP_EN
        s_axis_tkeep  = 32'h0000_0000;
`endif
    endtask

    // Cycle-accurate reference: busy/taken model predicts tready, tvalid and every output beat.
    task automatic run_stream(input int n, input bit bp, input int max_cyc);
        logic [63:0] exp_d [$];
        logic        exp_l [$];
        logic        busy;
        logic        exp_rdy;
        logic        in_hs;
        logic        out_hs;
        logic        cur_cfg;
        int          idx;
        int          taken;
        exp_d.delete();
        exp_l.delete();
        for (int i = 0; i < n; i++) begin
            if (!in_cfg[i]) begin
                for (int k = 0; k < 4; k++) begin
                    exp_d.push_back(slice_of(in_base[i], k));
                    exp_l.push_back(in_last[i] && (k == 3));
                end
            end
        end
        busy  = 1'b0;
        idx   = 0;
        taken = 0;
        if (n > 0) drive_beat(0);
        else drive_idle();
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            m_axis_tready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            @(negedge aclk);
            exp_rdy = !busy || (m_axis_tready && (taken % 4 == 3));
            check_value("s_tready", s_axis_tready, exp_rdy);
            check_value("m_tvalid", m_axis_tvalid, busy);
            check_value("m_tkeep", m_axis_tkeep, busy ? 8'hFF : 8'h00);
            if (busy && taken < exp_d.size()) begin
                check_value("m_tdata", m_axis_tdata, exp_d[taken]);
                check_value("m_tlast", m_axis_tlast, exp_l[taken]);
            end
            in_hs   = s_axis_tvalid && exp_rdy;
            cur_cfg = (idx < n) ? in_cfg[idx] : 1'b0;
            out_hs  = busy && m_axis_tready;
            @(posedge aclk);
            #1;
            if (in_hs && !cur_cfg) busy = 1'b1;
            else if (out_hs && (taken % 4 == 3)) busy = 1'b0;
            else busy = busy;
            if (out_hs) taken++;
            if (in_hs) begin
                idx++;
                if (idx < n) drive_beat(idx);
                else drive_idle();
            end
            if (idx >= n && taken >= exp_d.size() && !busy) break;
        end
        drive_idle();
        check_value("beats_out", taken, exp_d.size());
        check_value("beats_in", idx, n);
        @(negedge aclk);
        check_value("idle_tvalid", m_axis_tvalid, 1'b0);
        @(posedge aclk);
        #1;
    endtask

    initial begin
        areset        = 1'b1;
        m_axis_tready = 1'b0;
        drive_idle();
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        check_value("rst_tvalid", m_axis_tvalid, 1'b0);
        check_value("rst_tlast", m_axis_tlast, 1'b0);
        check_value("rst_tdata", m_axis_tdata, 64'd0);
        check_value("rst_tkeep", m_axis_tkeep, 8'h00);
        check_value("rst_tready", s_axis_tready, 1'b0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        check_value("tready_after_rst", s_axis_tready, 1'b1);
        @(posedge aclk);
        #1;

        // Serialization: words 0x00..0x1F, one packet
        in_base[0] = 8'h00; in_last[0] = 1'b1; in_cfg[0] = 1'b0;
        run_stream(1, 1'b0, 20);

        // Back-to-back: three beats, one packet
        in_base[0] = 8'h20; in_last[0] = 1'b0; in_cfg[0] = 1'b0;
        in_base[1] = 8'h40; in_last[1] = 1'b0; in_cfg[1] = 1'b0;
        in_base[2] = 8'h60; in_last[2] = 1'b1; in_cfg[2] = 1'b0;
        run_stream(3, 1'b0, 40);

        // Backpressure pattern 1,0,0,1 over two packets
        in_base[0] = 8'h80; in_last[0] = 1'b1; in_cfg[0] = 1'b0;
        in_base[1] = 8'hA0; in_last[1] = 1'b1; in_cfg[1] = 1'b0;
        run_stream(2, 1'b1, 80);

        // Config beat overlapped with the final drain of A
        in_base[0] = 8'h10; in_last[0] = 1'b1; in_cfg[0] = 1'b0;
        in_base[1] = 8'h55; in_last[1] = 1'b0; in_cfg[1] = 1'b1;
        in_base[2] = 8'h30; in_last[2] = 1'b1; in_cfg[2] = 1'b0;
        run_stream(3, 1'b0, 40);

        // Config beat arriving while empty
        in_base[0] = 8'h99; in_last[0] = 1'b1; in_cfg[0] = 1'b1;
        in_base[1] = 8'hE0; in_last[1] = 1'b1; in_cfg[1] = 1'b0;
        run_stream(2, 1'b0, 20);

        // Reset after two of four sub-beats
        m_axis_tready = 1'b1;
        in_base[0] = 8'hA0; in_last[0] = 1'b1; in_cfg[0] = 1'b0;
        drive_beat(0);
        @(negedge aclk);
        check_value("rd_accept", s_axis_tready, 1'b1);
        @(posedge aclk);
        #1;
        drive_idle();
        @(negedge aclk);
        check_value("rd_sub0", m_axis_tdata, slice_of(8'hA0, 0));
        @(posedge aclk);
        #1;
        @(negedge aclk);
        check_value("rd_sub1", m_axis_tdata, slice_of(8'hA0, 1));
        @(posedge aclk);
        #1;
        areset = 1'b1;
        @(negedge aclk);
        check_value("rd_tready_in_rst", s_axis_tready, 1'b0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        check_value("rd_tvalid", m_axis_tvalid, 1'b0);
        check_value("rd_tlast", m_axis_tlast, 1'b0);
        @(posedge aclk);
        #1;
        in_base[0] = 8'hC0; in_last[0] = 1'b1; in_cfg[0] = 1'b0;
        run_stream(1, 1'b0, 20);

`ifdef OUTPUT_PIPE_TKEEP_EN
        // Keep only in bytes 0..11 on a tlast beat: two sub-beats, next input taken at once
        m_axis_tready = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = beat_data(8'h00);
        s_axis_tlast  = 1'b1;
        s_axis_tuser  = 8'hF7;
        s_axis_tkeep  = 32'h0000_0FFF;
        @(negedge aclk);
        check_value("tk_accept", s_axis_tready, 1'b1);
        @(posedge aclk);
        #1;
        s_axis_tdata  = beat_data(8'h40);
        s_axis_tkeep  = 32'hFFFF_FFFF;
        @(negedge aclk);
        check_value("tk_b0_keep", m_axis_tkeep, 8'hFF);
        check_value("tk_b0_last", m_axis_tlast, 1'b0);
        check_value("tk_b0_rdy", s_axis_tready, 1'b0);
        @(posedge aclk);
        #1;
        @(negedge aclk);
        check_value("tk_b1_keep", m_axis_tkeep, 8'h0F);
        check_value("tk_b1_last", m_axis_tlast, 1'b1);
        check_value("tk_b1_data", m_axis_tdata, slice_of(8'h00, 1));
        check_value("tk_b1_rdy", s_axis_tready, 1'b1);
        @(posedge aclk);
        #1;
        drive_idle();
        @(negedge aclk);
        check_value("tk_next_valid", m_axis_tvalid, 1'b1);
        check_value("tk_next_data", m_axis_tdata, slice_of(8'h40, 0));
        check_value("tk_next_keep", m_axis_tkeep, 8'hFF);
        repeat (4) @(posedge aclk);
        @(negedge aclk);
        check_value("tk_drained", m_axis_tvalid, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/axis_output_pipe.md
# axis_output_pipe

Output-side counterpart of the conv-engine input pipe. It accepts wide result beats from the conv engine and buffers each one. It drops configuration beats, then serializes each result beat into narrower AXI-Stream beats toward the output DMA, preserving packet boundaries through tlast. It sits between the conv engine's result stream and the S2MM DMA port.

## Interface
Parameters:
- WORD_WIDTH, 8, bits per word
- S_WORDS, 32, words per input beat (conv engine result width)
- M_WORDS, 8, words per output beat. S_WORDS % M_WORDS == 0.
- RATIO, S_WORDS/M_WORDS (localparam), output beats per input beat; ≥1
- TUSER_WIDTH, 8, input tuser width
- I_IS_CONFIG, 3, index of the is-config flag in s_axis_tuser

Ports:
- aclk  in  1  clock; all logic on rising edge
- areset  in  1  reset, **synchronous, active-high**
- s_axis_tready  out  1  input ready
- s_axis_tvalid  in  1  input valid
- s_axis_tlast  in  1  last beat of output packet
- s_axis_tdata  in  S_WORDS*WORD_WIDTH  result words; word 0 in LSBs
- s_axis_tuser  in  TUSER_WIDTH  sideband; only bit I_IS_CONFIG is used
- s_axis_tkeep  in  S_WORDS*WORD_WIDTH/8  byte enables; present only with OUTPUT_PIPE_TKEEP_EN
- m_axis_tready  in  1  output ready
- m_axis_tvalid  out  1  output valid
- m_axis_tlast  out  1  packet end
- m_axis_tdata  out  M_WORDS*WORD_WIDTH  output words
- m_axis_tkeep  out  M_WORDS*WORD_WIDTH/8  byte enables

## Operation
- Datapath:
  - Holding register `hold_data` / `hold_keep` / `hold_last`.
  - Sub-beat counter `cnt`, width max(1, clog2(RATIO)).
  - `last_idx` register: index of the final sub-beat to emit.
- States:
  - EMPTY: m_axis_tvalid=0.
  - DRAIN: m_axis_tvalid=1, m_axis_tdata = hold_data slice [cnt].
- s_axis_tready = !areset && (state==EMPTY || (m_axis_tready && cnt==last_idx)).
- Input handshake (s_axis_tvalid && s_axis_tready):
  - With tuser[I_IS_CONFIG]=1: beat is consumed and discarded. Next state is EMPTY, unless this handshake coincided with the final drain, in which case it is also EMPTY.
  - Otherwise: load the hold register, cnt←0, compute last_idx, go to DRAIN.
- Output handshake (m_axis_tvalid && m_axis_tready):
  - If cnt<last_idx: cnt←cnt+1.
  - If cnt==last_idx: go to EMPTY, unless the same-cycle input load applies (load wins, giving back-to-back beats without a bubble).
- m_axis_tlast = hold_last && cnt==last_idx.
- Slice order: word 0 is sent first. Slice k = words [k*M_WORDS, (k+1)*M_WORDS).
- last_idx = RATIO-1 (see Configuration for the override).
- RATIO=1 degenerates to a full-throughput register slice.
- When m_axis_tready is low, m_axis_tdata, m_axis_tkeep and m_axis_tlast hold stable.
- areset asserted mid-drain: at the next edge, state←EMPTY, cnt←0, and the held beat is lost. No partial tlast is emitted.

## Timing
- Reset values (from the first edge with areset high):
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=0
  - s_axis_tready=0 while areset is high; 1 in the first cycle after areset falls
- Latency: input accepted at edge t, so the first output beat is valid in cycle t+1.
- Steady-state throughput:
  - Output side: one output beat per cycle.
  - Input side: one input beat per (last_idx+1) cycles.
- s_axis_tready depends combinationally on m_axis_tready. m_axis_* is fully registered.
- Config beats cost one cycle each when EMPTY, and zero extra cycles when overlapped with the final drain.

## Configuration
- Macro `OUTPUT_PIPE_TKEEP_EN`.
- Defined:
  - s_axis_tkeep port exists and is registered into hold_keep.
  - m_axis_tkeep = hold_keep slice [cnt].
  - On a tlast beat, last_idx = highest slice with any nonzero keep bit, or 0 if all slices are zero. Trailing empty sub-beats are not sent; tlast moves to last_idx.
  - Non-tlast beats always use last_idx = RATIO-1.
- Undefined:
  - No s_axis_tkeep port.
  - m_axis_tkeep is all ones whenever m_axis_tvalid=1, and 0 otherwise.
  - last_idx is always RATIO-1.

## Test plan
Defaults for all cases: WORD_WIDTH=8, S_WORDS=32, M_WORDS=8, RATIO=4.
- Serialization:
  - Stimulus: one beat with words 0x00..0x1F and tlast=1, m_axis_tready held at 1.
  - Response: 4 beats on consecutive cycles starting at t+1; beat k carries bytes 8k..8k+7; tlast only on beat 3; s_axis_tready=0 for beats 0–2.
- Back-to-back:
  - Stimulus: 3 beats presented continuously, tready=1.
  - Response: 12 output beats with no bubble; s_axis_tready=1 exactly on cycles where cnt==3.
- Backpressure:
  - Stimulus: m_axis_tready toggled with pattern 1,0,0,1,…
  - Response: data, tlast and tkeep stable while stalled; order and count unchanged; no loss or duplication.
- Config drop:
  - Stimulus: beats {data A}, {tuser[3]=1}, {data B}.
  - Response: only 8 output beats (A then B); the config beat produces no output.
- Reset mid-drain:
  - Stimulus: assert areset after 2 of 4 sub-beats, then send a new beat.
  - Response: m_axis_tvalid=0 on the next cycle; the new beat emits 4 clean sub-beats; no stray tlast.
- With OUTPUT_PIPE_TKEEP_EN:
  - Stimulus: tlast beat whose keep is nonzero only in bytes 0–11.
  - Response: 2 output beats; beat 1 has tkeep=0x0F and tlast=1; the next input is accepted immediately.
